// File: rtl/arb_pkg.sv
// Shared types and the rotate-priority search for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } arb_state_t;

  typedef logic [1:0] req_idx_t;

  // First requester at or after last+1, wrapping; last itself is checked last.
  function automatic req_idx_t rr_pick(input logic [N_REQ-1:0] req, input req_idx_t last);
    req_idx_t pick;
    logic     found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      req_idx_t cand;
      cand = last + req_idx_t'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the four clients and the arbiter.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  req_idx_t         gnt_idx;
  logic             timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_idx,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_idx,
    output timeout
  );

endinterface

// File: rtl/dec2to4.sv
// 2-to-4 one-hot decoder with enable; x is the index MSB, y the LSB.
module dec2to4 (
  input  logic       x,
  input  logic       y,
  input  logic       en,
  output logic [3:0] z
);

  always_comb begin
    z = '0;
    if (en) begin
      z[{x, y}] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters with max-hold timeout and a post-release idle gap.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter4_if.slave  bus
);

  localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned GW = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam bit TMO_EN  = (MAX_HOLD != 0);
  localparam bit GAP_EN  = (GAP_CYCLES != 0);

  arb_state_t        state_q, state_d;
  req_idx_t          last_q,  last_d;
  req_idx_t          idx_q,   idx_d;
  logic              valid_q, valid_d;
  logic              tmo_q,   tmo_d;
  logic [HW-1:0]     hold_q,  hold_d;
  logic [GW-1:0]     gap_q,   gap_d;

  req_idx_t          winner;
  logic              owner_req;
  logic              hold_expired;
  logic [N_REQ-1:0]  gnt_w;

  assign winner       = rr_pick(bus.req, last_q);
  assign owner_req    = bus.req[idx_q];
  assign hold_expired = TMO_EN && (hold_q == HOLD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      idx_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    tmo_d   = 1'b0;
    hold_d  = hold_q;
    gap_d   = gap_q;

    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          idx_d   = winner;
          valid_d = 1'b1;
          last_d  = winner;
          hold_d  = HW'(1);
        end
      end

      GRANT: begin
        // A still-asserted owner request here can only mean the hold limit expired.
        if (!owner_req || hold_expired) begin
          tmo_d   = owner_req;
          valid_d = 1'b0;
          idx_d   = '0;
          hold_d  = '0;
          if (GAP_EN) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q != '1) begin
          hold_d = hold_q + HW'(1);
        end
      end

      GAP: begin
        if (gap_q <= GW'(1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  dec2to4 u_dec (
    .x  (idx_q[1]),
    .y  (idx_q[0]),
    .en (valid_q),
    .z  (gnt_w)
  );

  assign bus.gnt       = gnt_w;
  assign bus.gnt_valid = valid_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.timeout   = tmo_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: three parameterisations against an ownership-level reference model.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;

  always #5 clk = ~clk;

  rr_arbiter4_if ifa ();
  rr_arbiter4_if ifb ();
  rr_arbiter4_if ifc ();

  assign ifa.req = req;
  assign ifb.req = req;
  assign ifc.req = req;

  rr_arbiter4 #(.MAX_HOLD(8), .GAP_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  rr_arbiter4 #(.MAX_HOLD(4), .GAP_CYCLES(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  rr_arbiter4 #(.MAX_HOLD(0), .GAP_CYCLES(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  logic [3:0] g  [3];
  logic       v  [3];
  logic [1:0] ix [3];
  logic       t  [3];

  assign g[0] = ifa.gnt;  assign v[0] = ifa.gnt_valid; assign ix[0] = ifa.gnt_idx; assign t[0] = ifa.timeout;
  assign g[1] = ifb.gnt;  assign v[1] = ifb.gnt_valid; assign ix[1] = ifb.gnt_idx; assign t[1] = ifb.timeout;
  assign g[2] = ifc.gnt;  assign v[2] = ifc.gnt_valid; assign ix[2] = ifc.gnt_idx; assign t[2] = ifc.timeout;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the resource, how long, and how many cycles arbitration is blocked.
  int MAXH [3] = '{8, 4, 0};
  int GAPC [3] = '{1, 1, 0};
  int m_own  [3];
  int m_last [3];
  int m_held [3];
  int m_blk  [3];
  bit m_tmo  [3];

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_own[d] = -1; m_last[d] = 3; m_held[d] = 0; m_blk[d] = 0; m_tmo[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [3:0] r);
    for (int d = 0; d < 3; d++) begin
      m_tmo[d] = 1'b0;
      if (m_own[d] >= 0) begin
        if (!r[m_own[d]] || (MAXH[d] != 0 && m_held[d] == MAXH[d])) begin
          m_tmo[d] = r[m_own[d]];
          m_own[d] = -1;
          m_blk[d] = GAPC[d];
        end else begin
          m_held[d]++;
        end
      end else if (m_blk[d] > 0) begin
        m_blk[d]--;
      end else if (r != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last[d] + k) % 4;
          if (m_own[d] < 0 && r[c]) m_own[d] = c;
        end
        m_last[d] = m_own[d];
        m_held[d] = 1;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      logic [3:0] eg;
      eg = (m_own[d] >= 0) ? 4'(1 << m_own[d]) : 4'b0000;
      cmp($sformatf("gnt[%0d]", d),   8'(g[d]),  8'(eg));
      cmp($sformatf("valid[%0d]", d), 8'(v[d]),  8'(m_own[d] >= 0));
      cmp($sformatf("idx[%0d]", d),   8'(ix[d]), 8'((m_own[d] >= 0) ? m_own[d] : 0));
      cmp($sformatf("tmo[%0d]", d),   8'(t[d]),  8'(m_tmo[d]));
    end
  endtask

  task automatic step(input logic r_rst, input logic [3:0] r);
    @(negedge clk);
    rst = r_rst;
    req = r;
    if (r_rst) model_reset();
    @(posedge clk);
    if (!rst) model_edge(req);
    #1;
    check_all();
  endtask

  // Raise rst between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    cmp("async_gnt_a", 8'(g[0]), 8'h00);
    check_all();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       tmo;
  } vec_t;

  vec_t tbl [18];

  logic [1:0] order [$];
  int  cnt_a, cnt_b, cnt_c, gnt_b, gnt_c;
  logic prev_v;
  logic [3:0] r;

  initial begin
    // DUT A (MAX_HOLD=8, GAP=1): reset, release, fairness after owner
    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 4'b0001, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 1'b0};
    tbl[5]  = '{1'b0, 4'b0100, 4'b0100, 1'b0};
    tbl[6]  = '{1'b0, 4'b0100, 4'b0100, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{1'b0, 4'b0010, 4'b0010, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[11] = '{1'b0, 4'b0011, 4'b0000, 1'b0};
    tbl[12] = '{1'b0, 4'b0011, 4'b0001, 1'b0};
    tbl[13] = '{1'b0, 4'b0010, 4'b0000, 1'b0};
    tbl[14] = '{1'b0, 4'b0010, 4'b0000, 1'b0};
    tbl[15] = '{1'b0, 4'b0010, 4'b0010, 1'b0};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[17] = '{1'b0, 4'b0000, 4'b0000, 1'b0};

    model_reset();
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].req);
      cmp($sformatf("tbl%0d_gnt", i), 8'(g[0]), 8'(tbl[i].gnt));
      cmp($sformatf("tbl%0d_tmo", i), 8'(t[0]), 8'(tbl[i].tmo));
    end

    // Async reset while requester 3 owns the resource
    step(1'b0, 4'b1000);
    cmp("own3_gnt", 8'(g[0]), 8'h08);
    req = 4'b1111;
    async_reset();
    step(1'b1, 4'b1111);
    step(1'b0, 4'b1111);
    cmp("post_rst_gnt", 8'(g[0]), 8'h01);

    // All requesting: A rotates 0,1,2,3,0 with a timeout at each handover
    step(1'b1, 4'b1111);
    cnt_a = 0; cnt_b = 0; prev_v = 1'b0;
    order.delete();
    for (int n = 0; n < 45; n++) begin
      step(1'b0, 4'b1111);
      if (v[0] && !prev_v) order.push_back(ix[0]);
      prev_v = v[0];
      cnt_a += int'(t[0]);
      cnt_b += int'(t[1]);
    end
    cmp("rr_grants", 8'(order.size()), 8'd5);
    for (int i = 0; i < order.size(); i++)
      cmp($sformatf("rr_order%0d", i), 8'(order[i]), 8'(i % 4));
    cmp("rr_tmo_a", 8'(cnt_a), 8'd4);
    cmp("rr_tmo_b", 8'(cnt_b), 8'd7);

    // Single hog on requester 2
    step(1'b1, 4'b0100);
    gnt_b = 0; cnt_b = 0; gnt_c = 0; cnt_c = 0;
    for (int n = 0; n < 24; n++) begin
      step(1'b0, 4'b0100);
      gnt_b += int'(g[1][2]);
      cnt_b += int'(t[1]);
      gnt_c += int'(g[2][2]);
      cnt_c += int'(t[2]);
    end
    cmp("hog_gnt_b", 8'(gnt_b), 8'd16);
    cmp("hog_tmo_b", 8'(cnt_b), 8'd4);
    cmp("hog_gnt_c", 8'(gnt_c), 8'd24);
    cmp("hog_tmo_c", 8'(cnt_c), 8'd0);

    // Random traffic against the model
    step(1'b1, 4'b0000);
    r = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        req = r;
        async_reset();
      end
      step(1'b0, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
